// File: rtl/mac_pkg.sv
// Shared constants and helpers for the vector dot-product engine: default
// geometry, a constant-evaluable clog2 and the derived lane-slice widths.
package mac_pkg;

  localparam int DEF_DATAW    = 8;
  localparam int DEF_VECTOR_W = 10;
  localparam int DEF_ACCW     = 40;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int DEF_PROD_W     = 2 * DEF_DATAW;
  localparam int DEF_LANE_BUS_W = DEF_DATAW * DEF_VECTOR_W;
  localparam int DEF_SUM_W      = DEF_PROD_W + clog2(DEF_VECTOR_W);

endpackage

// File: rtl/mac_vec_adder_tree.sv
// Stage 2 of the dot-product pipeline: sums VECTOR_W lane products and
// registers the total sign/zero-extended to OUT_W bits.
module mac_vec_adder_tree
  import mac_pkg::*;
#(
  parameter int VECTOR_W = DEF_VECTOR_W,
  parameter int PROD_W   = DEF_PROD_W,
  parameter int OUT_W    = DEF_ACCW,
  parameter int SIGNED   = 1
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       en,
  input  logic [VECTOR_W*PROD_W-1:0] prods,
  output logic [OUT_W-1:0]           sum
);

  // Internal width is just wide enough that the lane sum never overflows.
  localparam int TREE_W = PROD_W + clog2(VECTOR_W);

  logic [PROD_W-1:0] lane_s;
  logic [TREE_W-1:0] ext_s;
  logic [TREE_W-1:0] tree_s;
  logic [OUT_W-1:0]  sum_ext_s;

  // Lane products extended to the tree width and summed.
  always_comb begin
    tree_s = '0;
    lane_s = '0;
    ext_s  = '0;
    for (int i = 0; i < VECTOR_W; i++) begin
      lane_s = prods[i*PROD_W +: PROD_W];
      if (SIGNED != 32'sd0) begin
        ext_s = {TREE_W{lane_s[PROD_W-1]}};
      end else begin
        ext_s = '0;
      end
      ext_s[PROD_W-1:0] = lane_s;
      tree_s = tree_s + ext_s;
    end
  end

  // Tree total extended to the output width.
  always_comb begin
    if (SIGNED != 32'sd0) begin
      sum_ext_s = {OUT_W{tree_s[TREE_W-1]}};
    end else begin
      sum_ext_s = '0;
    end
    sum_ext_s[TREE_W-1:0] = tree_s;
  end

  // Sum register, held while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (!clr) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum_ext_s;
    end
  end

endmodule

// File: rtl/mac_vec_dpe.sv
// Vector dot-product engine: double-buffered weights, 3-stage multiply /
// adder-tree / accumulate pipeline with output backpressure and cascade taps.
// Define MAC_VEC_SAT_EN to make the accumulator saturate and drive ovf.
module mac_vec_dpe
  import mac_pkg::*;
#(
  parameter int DATAW    = DEF_DATAW,
  parameter int VECTOR_W = DEF_VECTOR_W,
  parameter int ACCW     = DEF_ACCW,
  parameter int SIGNED   = 1,
  parameter int TILE_ID  = 0,
  parameter int DPE_ID   = 0
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  input  logic [DATAW*VECTOR_W-1:0] data_in,
  input  logic                      w_load,
  input  logic                      w_bank,
  input  logic [DATAW*VECTOR_W-1:0] w_in,
  input  logic                      bank_swap,
  output logic                      active_bank,
  input  logic                      zero_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACCW-1:0]           result,
  output logic                      ovf,
  output logic [DATAW*VECTOR_W-1:0] cascade_data_out,
  output logic [DATAW*VECTOR_W-1:0] cascade_weight_out
);

  localparam int PROD_W = 2 * DATAW;
  localparam int BUS_W  = DATAW * VECTOR_W;

  // Identification parameters carry no logic.
  if (TILE_ID < 0 || DPE_ID < 0) begin : g_id_negative
  end

  logic [BUS_W-1:0]           bank0_r;
  logic [BUS_W-1:0]           bank1_r;
  logic [BUS_W-1:0]           wsel_s;
  logic [VECTOR_W*PROD_W-1:0] prod_s;
  logic [VECTOR_W*PROD_W-1:0] prod_r;
  logic [DATAW-1:0]           lane_d_s;
  logic [DATAW-1:0]           lane_w_s;
  logic                       v1_r, l1_r, v2_r, l2_r;
  logic [ACCW-1:0]            sum_s;
  logic [ACCW-1:0]            acc_r;
  logic [ACCW-1:0]            add_s;
  logic                       advance_s;
  logic                       done_s;

  assign advance_s = !(out_valid && !out_ready);
  assign in_ready  = advance_s;
  assign wsel_s    = active_bank ? bank1_r : bank0_r;
  assign done_s    = advance_s && v2_r && l2_r && !zero_en;

  // Weight banks and active-bank toggle; reads see pre-edge contents.
  always_ff @(posedge clk) begin
    if (!clr) begin
      bank0_r     <= '0;
      bank1_r     <= '0;
      active_bank <= 1'b0;
    end else begin
      if (w_load) begin
        if (w_bank) begin
          bank1_r <= w_in;
        end else begin
          bank0_r <= w_in;
        end
      end
      if (bank_swap) begin
        active_bank <= !active_bank;
      end
    end
  end

  // Per-lane products against the active bank.
  always_comb begin
    prod_s   = '0;
    lane_d_s = '0;
    lane_w_s = '0;
    for (int i = 0; i < VECTOR_W; i++) begin
      lane_d_s = data_in[i*DATAW +: DATAW];
      lane_w_s = wsel_s[i*DATAW +: DATAW];
      if (SIGNED != 32'sd0) begin
        prod_s[i*PROD_W +: PROD_W] = {{DATAW{lane_d_s[DATAW-1]}}, lane_d_s}
                                   * {{DATAW{lane_w_s[DATAW-1]}}, lane_w_s};
      end else begin
        prod_s[i*PROD_W +: PROD_W] = {{DATAW{1'b0}}, lane_d_s}
                                   * {{DATAW{1'b0}}, lane_w_s};
      end
    end
  end

  // Stage 1: product register, beat tags and cascade taps.
  always_ff @(posedge clk) begin
    if (!clr) begin
      prod_r             <= '0;
      v1_r               <= 1'b0;
      l1_r               <= 1'b0;
      cascade_data_out   <= '0;
      cascade_weight_out <= '0;
    end else if (zero_en) begin
      v1_r <= 1'b0;
    end else if (advance_s) begin
      prod_r <= prod_s;
      v1_r   <= in_valid;
      l1_r   <= in_last;
      if (in_valid) begin
        cascade_data_out   <= data_in;
        cascade_weight_out <= wsel_s;
      end
    end
  end

  mac_vec_adder_tree #(
    .VECTOR_W (VECTOR_W),
    .PROD_W   (PROD_W),
    .OUT_W    (ACCW),
    .SIGNED   (SIGNED)
  ) u_tree (
    .clk   (clk),
    .clr   (clr),
    .en    (advance_s),
    .prods (prod_r),
    .sum   (sum_s)
  );

  // Stage 2 tags travel alongside the adder-tree register.
  always_ff @(posedge clk) begin
    if (!clr) begin
      v2_r <= 1'b0;
      l2_r <= 1'b0;
    end else if (zero_en) begin
      v2_r <= 1'b0;
    end else if (advance_s) begin
      v2_r <= v1_r;
      l2_r <= l1_r;
    end
  end

`ifdef MAC_VEC_SAT_EN
  logic [ACCW:0] wide_s;
  logic          clamp_s;

  // Accumulate with one guard bit, clamping to the representable range.
  always_comb begin
    wide_s  = '0;
    add_s   = '0;
    clamp_s = 1'b0;
    if (SIGNED != 32'sd0) begin
      wide_s = {acc_r[ACCW-1], acc_r} + {sum_s[ACCW-1], sum_s};
      if (wide_s[ACCW] != wide_s[ACCW-1]) begin
        clamp_s = 1'b1;
        if (wide_s[ACCW]) begin
          add_s = {1'b1, {(ACCW-1){1'b0}}};
        end else begin
          add_s = {1'b0, {(ACCW-1){1'b1}}};
        end
      end else begin
        add_s = wide_s[ACCW-1:0];
      end
    end else begin
      wide_s = {1'b0, acc_r} + {1'b0, sum_s};
      if (wide_s[ACCW]) begin
        clamp_s = 1'b1;
        add_s   = '1;
      end else begin
        add_s = wide_s[ACCW-1:0];
      end
    end
  end

  // Sticky overflow flag, cleared together with the accumulator.
  always_ff @(posedge clk) begin
    if (!clr) begin
      ovf <= 1'b0;
    end else if (zero_en) begin
      ovf <= 1'b0;
    end else if (advance_s && v2_r && clamp_s) begin
      ovf <= 1'b1;
    end
  end
`else
  assign add_s = acc_r + sum_s;
  assign ovf   = 1'b0;
`endif

  // Stage 3: accumulate, publish on the last beat, output handshake.
  always_ff @(posedge clk) begin
    if (!clr) begin
      acc_r     <= '0;
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      if (zero_en) begin
        acc_r <= '0;
      end else if (advance_s && v2_r) begin
        if (l2_r) begin
          result <= add_s;
          acc_r  <= '0;
        end else begin
          acc_r <= add_s;
        end
      end
      if (done_s) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_vec_dpe.sv
// Directed self-checking bench for mac_vec_dpe: a default signed instance,
// an unsigned instance and a narrow 20-bit accumulator instance share stimulus.
module tb_mac_vec_dpe;

  logic        clk = 1'b0;
  logic        clr;
  logic        in_valid, in_last, w_load, w_bank, bank_swap, zero_en, out_ready;
  logic [79:0] data_in, w_in;

  logic        a_in_ready, a_active_bank, a_out_valid, a_ovf;
  logic [39:0] a_result;
  logic [79:0] a_cas_d, a_cas_w;
  logic        b_in_ready, b_active_bank, b_out_valid, b_ovf;
  logic [39:0] b_result;
  logic [79:0] b_cas_d, b_cas_w;
  logic        c_in_ready, c_active_bank, c_out_valid, c_ovf;
  logic [19:0] c_result;
  logic [79:0] c_cas_d, c_cas_w;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mac_vec_dpe u_a (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(a_in_ready), .in_last(in_last),
    .data_in(data_in), .w_load(w_load), .w_bank(w_bank), .w_in(w_in), .bank_swap(bank_swap),
    .active_bank(a_active_bank), .zero_en(zero_en), .out_valid(a_out_valid),
    .out_ready(out_ready), .result(a_result), .ovf(a_ovf),
    .cascade_data_out(a_cas_d), .cascade_weight_out(a_cas_w));

  mac_vec_dpe #(.SIGNED(0)) u_b (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(b_in_ready), .in_last(in_last),
    .data_in(data_in), .w_load(w_load), .w_bank(w_bank), .w_in(w_in), .bank_swap(bank_swap),
    .active_bank(b_active_bank), .zero_en(zero_en), .out_valid(b_out_valid),
    .out_ready(out_ready), .result(b_result), .ovf(b_ovf),
    .cascade_data_out(b_cas_d), .cascade_weight_out(b_cas_w));

  mac_vec_dpe #(.ACCW(20), .SIGNED(1)) u_c (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(c_in_ready), .in_last(in_last),
    .data_in(data_in), .w_load(w_load), .w_bank(w_bank), .w_in(w_in), .bank_swap(bank_swap),
    .active_bank(c_active_bank), .zero_en(zero_en), .out_valid(c_out_valid),
    .out_ready(out_ready), .result(c_result), .ovf(c_ovf),
    .cascade_data_out(c_cas_d), .cascade_weight_out(c_cas_w));

  function automatic logic [79:0] ramp(input int start, input int step);
    logic [79:0] v;
    v = '0;
    for (int i = 0; i < 10; i++) v[i*8 +: 8] = 8'(start + i * step);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b0;
    tick();
    clr = 1'b1;
  endtask

  task automatic load_bank(input logic bank, input logic [79:0] w);
    w_load = 1'b1; w_bank = bank; w_in = w;
    tick();
    w_load = 1'b0; w_bank = 1'b0;
  endtask

  task automatic test_reset();
    logic [79:0] z;
    z = '0;
    clr = 1'b0; in_valid = 1'b1; in_last = 1'b1; data_in = ramp(1, 1);
    w_load = 1'b1; w_in = ramp(5, 1); bank_swap = 1'b1; zero_en = 1'b1;
    tick(); tick();
    clr = 1'b1; in_valid = 1'b0; in_last = 1'b0; w_load = 1'b0; bank_swap = 1'b0; zero_en = 1'b0;
    n_checks++; if (a_in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", a_in_ready); else n_pass++;
    n_checks++; if (a_out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", a_out_valid); else n_pass++;
    n_checks++; if (a_result !== 40'd0) $display("FAIL reset_result: got %0d expected 0", a_result); else n_pass++;
    n_checks++; if (a_active_bank !== 1'b0) $display("FAIL reset_active_bank: got %b expected 0", a_active_bank); else n_pass++;
    n_checks++; if (a_ovf !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", a_ovf); else n_pass++;
    n_checks++; if (a_cas_d !== z || a_cas_w !== z) $display("FAIL reset_cascade: got %h/%h expected 0", a_cas_d, a_cas_w); else n_pass++;
    tick(); tick(); tick();
    n_checks++; if (a_out_valid !== 1'b0) $display("FAIL reset_discard: got out_valid %b expected 0", a_out_valid); else n_pass++;
  endtask

  task automatic test_basic();
    load_bank(1'b0, ramp(10, -1));
    in_valid = 1'b1; in_last = 1'b1; data_in = ramp(1, 1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    n_checks++; if (a_cas_d !== ramp(1, 1)) $display("FAIL basic_cascade_data: got %h expected %h", a_cas_d, ramp(1, 1)); else n_pass++;
    n_checks++; if (a_cas_w !== ramp(10, -1)) $display("FAIL basic_cascade_weight: got %h expected %h", a_cas_w, ramp(10, -1)); else n_pass++;
    tick();
    n_checks++; if (a_out_valid !== 1'b0) $display("FAIL basic_early_valid: got %b expected 0", a_out_valid); else n_pass++;
    tick();
    n_checks++; if (a_out_valid !== 1'b1) $display("FAIL basic_out_valid: got %b expected 1", a_out_valid); else n_pass++;
    n_checks++; if (a_result !== 40'd220) $display("FAIL basic_result: got %0d expected 220", a_result); else n_pass++;
    tick();
    n_checks++; if (a_out_valid !== 1'b0) $display("FAIL basic_consumed: got %b expected 0", a_out_valid); else n_pass++;
  endtask

  task automatic test_bank_swap();
    load_bank(1'b1, ramp(3, 1));
    in_valid = 1'b1; in_last = 1'b1; data_in = ramp(1, 1); bank_swap = 1'b1;
    tick();
    bank_swap = 1'b0;
    n_checks++; if (a_active_bank !== 1'b1) $display("FAIL swap_active_bank: got %b expected 1", a_active_bank); else n_pass++;
    n_checks++; if (a_cas_w !== ramp(10, -1)) $display("FAIL swap_old_bank: got %h expected %h", a_cas_w, ramp(10, -1)); else n_pass++;
    data_in = ramp(-5, 1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    n_checks++; if (a_cas_w !== ramp(3, 1)) $display("FAIL swap_new_bank: got %h expected %h", a_cas_w, ramp(3, 1)); else n_pass++;
    tick();
    n_checks++; if (a_out_valid !== 1'b1 || a_result !== 40'd220) $display("FAIL swap_first_result: got %b/%0d expected 1/220", a_out_valid, a_result); else n_pass++;
    tick();
    n_checks++; if (a_out_valid !== 1'b1 || a_result !== 40'd45) $display("FAIL swap_second_result: got %b/%0d expected 1/45", a_out_valid, a_result); else n_pass++;
    tick();
    n_checks++; if (a_out_valid !== 1'b0) $display("FAIL swap_consumed: got %b expected 0", a_out_valid); else n_pass++;
  endtask

  task automatic test_unsigned();
    do_clr();
    load_bank(1'b0, ramp(255, 0));
    in_valid = 1'b1; in_last = 1'b1; data_in = ramp(255, 0);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    tick(); tick();
    n_checks++; if (b_out_valid !== 1'b1 || b_result !== 40'd650250) $display("FAIL unsigned_result: got %b/%0d expected 1/650250", b_out_valid, b_result); else n_pass++;
    n_checks++; if (a_result !== 40'd10) $display("FAIL signed_minus_one: got %0d expected 10", a_result); else n_pass++;
    tick();
  endtask

  task automatic test_backpressure();
    do_clr();
    load_bank(1'b0, ramp(10, -1));
    out_ready = 1'b0;
    in_valid = 1'b1; in_last = 1'b0; data_in = ramp(1, 1);
    tick(); tick();
    in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    tick(); tick();
    n_checks++; if (a_out_valid !== 1'b1 || a_result !== 40'd660) $display("FAIL bp_result: got %b/%0d expected 1/660", a_out_valid, a_result); else n_pass++;
    in_valid = 1'b1; in_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++; if (a_in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b expected 0", a_in_ready); else n_pass++;
      n_checks++; if (a_out_valid !== 1'b1 || a_result !== 40'd660) $display("FAIL bp_hold: got %b/%0d expected 1/660", a_out_valid, a_result); else n_pass++;
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    n_checks++; if (a_out_valid !== 1'b0) $display("FAIL bp_release: got %b expected 0", a_out_valid); else n_pass++;
    tick(); tick();
    n_checks++; if (a_out_valid !== 1'b1 || a_result !== 40'd220) $display("FAIL bp_held_beat: got %b/%0d expected 1/220", a_out_valid, a_result); else n_pass++;
    tick();
    n_checks++; if (a_out_valid !== 1'b0) $display("FAIL bp_no_duplicate: got %b expected 0", a_out_valid); else n_pass++;
  endtask

  task automatic test_saturate();
    logic [19:0] exp_res;
    logic        exp_ovf;
`ifdef MAC_VEC_SAT_EN
    exp_res = 20'h7FFFF;
    exp_ovf = 1'b1;
`else
    exp_res = 20'd645160; // -403416 in 20-bit two's complement
    exp_ovf = 1'b0;
`endif
    do_clr();
    load_bank(1'b0, ramp(127, 0));
    in_valid = 1'b1; in_last = 1'b0; data_in = ramp(127, 0);
    tick(); tick(); tick();
    in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    tick(); tick();
    n_checks++; if (c_out_valid !== 1'b1 || c_result !== exp_res) $display("FAIL sat_result: got %b/%0d expected 1/%0d", c_out_valid, c_result, exp_res); else n_pass++;
    n_checks++; if (c_ovf !== exp_ovf) $display("FAIL sat_ovf: got %b expected %b", c_ovf, exp_ovf); else n_pass++;
    n_checks++; if (a_result !== 40'd645160 || a_ovf !== 1'b0) $display("FAIL wide_no_ovf: got %0d/%b expected 645160/0", a_result, a_ovf); else n_pass++;
    tick();
  endtask

  task automatic test_zero();
    load_bank(1'b0, ramp(10, -1));
    in_valid = 1'b1; in_last = 1'b0; data_in = ramp(1, 1);
    tick(); tick();
    zero_en = 1'b1;
    tick();
    zero_en = 1'b0;
    n_checks++; if (c_ovf !== 1'b0) $display("FAIL zero_ovf_clear: got %b expected 0", c_ovf); else n_pass++;
    in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    n_checks++; if (a_out_valid !== 1'b0) $display("FAIL zero_early_valid: got %b expected 0", a_out_valid); else n_pass++;
    tick();
    n_checks++; if (a_out_valid !== 1'b1 || a_result !== 40'd220) $display("FAIL zero_result: got %b/%0d expected 1/220", a_out_valid, a_result); else n_pass++;
    tick();
    in_valid = 1'b1; in_last = 1'b1; data_in = ramp(1, 1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    clr = 1'b0;
    tick();
    clr = 1'b1;
    tick(); tick(); tick();
    n_checks++; if (a_out_valid !== 1'b0 || a_result !== 40'd0) $display("FAIL midclr_flush: got %b/%0d expected 0/0", a_out_valid, a_result); else n_pass++;
    n_checks++; if (a_in_ready !== 1'b1) $display("FAIL midclr_in_ready: got %b expected 1", a_in_ready); else n_pass++;
  endtask

  initial begin
    clr = 1'b0; in_valid = 1'b0; in_last = 1'b0; w_load = 1'b0; w_bank = 1'b0;
    bank_swap = 1'b0; zero_en = 1'b0; out_ready = 1'b1; data_in = '0; w_in = '0;
    test_reset();
    test_basic();
    test_bank_swap();
    test_unsigned();
    test_backpressure();
    test_saturate();
    test_zero();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
